gmii_tx_sched: RTL and testbench

Frame scheduler that sequences the GMII transmit datapath and shares it between two byte-stream requesters. It arbitrates round-robin per frame, generates the Ethernet preamble and SFD, streams the granted requester's payload and enforces the inter-packet gap. It also handles requester underrun by truncating the frame on the wire and draining the rest of that frame. Its `o_dv`/`o_data` outputs drive `i_dv`/`i_data` of the downstream GMII transmit register stage.

---
 rtl/gmii_tx_sched.sv | 209 ++++++++++++++++++++
 tb/tb_gmii_tx_sched.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_sched.sv
// ---------------------------------------------------------------------------
// gmii_tx_sched
//   Frame scheduler in front of the GMII transmit register stage. Two
//   byte-stream requesters share the wire; ownership is decided per frame
//   with a round-robin tie-break. For every frame the block emits the
//   preamble and SFD, forwards the granted requester's bytes and then holds
//   the line idle for the inter-packet gap. If the owner stalls mid-frame,
//   the frame is cut short on the wire and the rest of it is drained.
//
// Ports
//   clk          : single clock domain
//   i_reset      : synchronous, active-high reset
//   i_valid[1:0] : per-requester byte valid (index 0 = requester 0)
//   i_data[1:0]  : per-requester payload byte
//   i_last[1:0]  : per-requester end-of-frame marker, qualified by valid
//   o_ready[1:0] : per-requester accept (combinational, granted index only)
//   o_dv         : registered data-valid to the transmit stage
//   o_data       : registered byte to the transmit stage (0 when o_dv low)
//   o_grant      : registered one-hot owner of the current frame
//   o_underrun   : registered one-cycle pulse when a frame is truncated
//   o_frame_cnt  : frames completed without underrun, modulo 2^16
// ---------------------------------------------------------------------------
module gmii_tx_sched #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_CYCLES   = 12
) (
    input  logic            clk,
    input  logic            i_reset,
    input  logic [1:0]      i_valid,
    input  logic [1:0][7:0] i_data,
    input  logic [1:0]      i_last,
    output logic [1:0]      o_ready,
    output logic            o_dv,
    output logic [7:0]      o_data,
    output logic [1:0]      o_grant,
    output logic            o_underrun,
    output logic [15:0]     o_frame_cnt
);

    localparam logic [3:0] PRE_LOAD = 4'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IPG_LOAD = 8'(IPG_CYCLES - 1);

    // The state names what is on the wire in the current cycle; the output
    // registers are loaded with what the next state will show.
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_PAYLOAD,
        S_DRAIN,
        S_IPG
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  ipg_cnt_q, ipg_cnt_d;
    logic        gnt_q, gnt_d;      // index of the current owner
    logic        rr_q, rr_d;        // index granted most recently

    logic        dv_q, dv_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  grant_q, grant_d;
    logic        underrun_q, underrun_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        req_any;
    logic        pick;
    logic        offer;
    logic        g_valid;
    logic        g_last;
    logic [7:0]  g_data;

    assign req_any = |i_valid;
    // On a tie the requester not served last wins.
    assign pick    = (i_valid == 2'b11) ? ~rr_q : i_valid[1];
    // The SFD cycle already offers ready so the first payload byte follows
    // the SFD without a gap.
    assign offer   = (state_q == S_SFD) || (state_q == S_PAYLOAD) ||
                     (state_q == S_DRAIN);
    assign g_valid = i_valid[gnt_q];
    assign g_last  = i_last[gnt_q];
    assign g_data  = i_data[gnt_q];

    // State register
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= '0;
            ipg_cnt_q <= '0;
            gnt_q     <= 1'b0;
            rr_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            ipg_cnt_q <= ipg_cnt_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        ipg_cnt_d = ipg_cnt_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    state_d   = S_PRE;
                    pre_cnt_d = PRE_LOAD;
                    gnt_d     = pick;
                    rr_d      = pick;
                end
            end
            S_PRE: begin
                if (pre_cnt_q == 4'd0) state_d = S_SFD;
                else                   pre_cnt_d = pre_cnt_q - 4'd1;
            end
            S_SFD, S_PAYLOAD: begin
                if (!g_valid) begin
                    state_d = S_DRAIN;
                end else if (g_last) begin
                    state_d   = S_IPG;
                    ipg_cnt_d = IPG_LOAD;
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_DRAIN: begin
                if (g_valid && g_last) begin
                    state_d   = S_IPG;
                    ipg_cnt_d = IPG_LOAD;
                end
            end
            S_IPG: begin
                if (ipg_cnt_q == 8'd0) state_d = S_IDLE;
                else                   ipg_cnt_d = ipg_cnt_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_ready = 2'b00;
        if (offer && !i_reset) o_ready[gnt_q] = 1'b1;

        dv_d        = 1'b0;
        data_d      = 8'h00;
        grant_d     = grant_q;
        underrun_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    dv_d    = 1'b1;
                    data_d  = 8'h55;
                    grant_d = pick ? 2'b10 : 2'b01;
                end
            end
            S_PRE: begin
                dv_d   = 1'b1;
                data_d = (pre_cnt_q == 4'd0) ? 8'hD5 : 8'h55;
            end
            S_SFD, S_PAYLOAD: begin
                if (g_valid) begin
                    dv_d   = 1'b1;
                    data_d = g_data;
                    if (g_last) begin
                        grant_d     = 2'b00;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (g_valid && g_last) grant_d = 2'b00;
            end
            default: grant_d = 2'b00;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (i_reset) begin
            dv_q        <= 1'b0;
            data_q      <= 8'h00;
            grant_q     <= 2'b00;
            underrun_q  <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            dv_q        <= dv_d;
            data_q      <= data_d;
            grant_q     <= grant_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_dv        = dv_q;
    assign o_data      = data_q;
    assign o_grant     = grant_q;
    assign o_underrun  = underrun_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_gmii_tx_sched
//   Directed bench for gmii_tx_sched. A default-parameter instance is driven
//   from two byte queues (bit 8 = last); a second instance with the shortest
//   preamble and gap is driven directly with single-byte frames.
// ---------------------------------------------------------------------------
module tb_gmii_tx_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            i_reset;
    logic [1:0]      i_valid;
    logic [1:0][7:0] i_data;
    logic [1:0]      i_last;
    logic [1:0]      o_ready;
    logic            o_dv;
    logic [7:0]      o_data;
    logic [1:0]      o_grant;
    logic            o_underrun;
    logic [15:0]     o_frame_cnt;

    logic [1:0]      s_valid;
    logic [1:0][7:0] s_data;
    logic [1:0]      s_last;
    logic [1:0]      s_ready;
    logic            s_dv;
    logic [7:0]      s_odata;
    logic [1:0]      s_grant;
    logic            s_underrun;
    logic [15:0]     s_frame_cnt;

    gmii_tx_sched dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_last      (i_last),
        .o_ready     (o_ready),
        .o_dv        (o_dv),
        .o_data      (o_data),
        .o_grant     (o_grant),
        .o_underrun  (o_underrun),
        .o_frame_cnt (o_frame_cnt)
    );

    gmii_tx_sched #(.PREAMBLE_LEN(1), .IPG_CYCLES(1)) dut_s (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_valid     (s_valid),
        .i_data      (s_data),
        .i_last      (s_last),
        .o_ready     (s_ready),
        .o_dv        (s_dv),
        .o_data      (s_odata),
        .o_grant     (s_grant),
        .o_underrun  (s_underrun),
        .o_frame_cnt (s_frame_cnt)
    );

    int checks = 0;
    int passed = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       en0 = 1'b1;
    logic       en1 = 1'b1;

    task automatic push0(input logic [7:0] d, input logic l);
        q0.push_back({l, d});
    endtask

    task automatic push1(input logic [7:0] d, input logic l);
        q1.push_back({l, d});
    endtask

    task automatic drive();
        logic [8:0] h;
        i_valid = 2'b00;
        i_data  = '0;
        i_last  = 2'b00;
        if (q0.size() > 0) begin
            h = q0[0];
            i_valid[0] = en0;
            i_data[0]  = h[7:0];
            i_last[0]  = h[8];
        end
        if (q1.size() > 0) begin
            h = q1[0];
            i_valid[1] = en1;
            i_data[1]  = h[7:0];
            i_last[1]  = h[8];
        end
    endtask

    // One clock: present queue heads, note handshakes, advance past the edge.
    task automatic cycle();
        logic x0, x1;
        drive();
        #1;
        x0 = i_valid[0] & o_ready[0];
        x1 = i_valid[1] & o_ready[1];
        @(posedge clk);
        #1;
        if (x0) void'(q0.pop_front());
        if (x1) void'(q1.pop_front());
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        q0.delete();
        q1.delete();
        en0 = 1'b1;
        en1 = 1'b1;
        s_valid = 2'b00;
        s_last  = 2'b00;
        cycle();
        cycle();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        push0(8'hEE, 1'b1);
        push1(8'hEF, 1'b1);
        cycle();
        cycle();
        drive();
        #1;
        checks++; if (o_ready !== 2'b00) $display("FAIL reset_ready got %b want 00", o_ready); else passed++;
        checks++; if (o_dv !== 1'b0) $display("FAIL reset_dv got %b want 0", o_dv); else passed++;
        checks++; if (o_data !== 8'h00) $display("FAIL reset_data got %h want 00", o_data); else passed++;
        checks++; if (o_grant !== 2'b00) $display("FAIL reset_grant got %b want 00", o_grant); else passed++;
        checks++; if (o_underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", o_underrun); else passed++;
        checks++; if (o_frame_cnt !== 16'h0000) $display("FAIL reset_frame_cnt got %h want 0000", o_frame_cnt); else passed++;
        checks++; if (s_dv !== 1'b0) $display("FAIL reset_small_dv got %b want 0", s_dv); else passed++;
        q0.delete();
        q1.delete();
        cycle();
        i_reset = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [7:0] ed[24];
        logic       edv[24];
        logic       saw_r1, saw_un;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            ed[k] = 8'h00;
            edv[k] = 1'b0;
        end
        for (int k = 0; k < 7; k++) begin
            ed[k] = 8'h55;
            edv[k] = 1'b1;
        end
        ed[7] = 8'hD5;  edv[7] = 1'b1;
        ed[8] = 8'h01;  edv[8] = 1'b1;
        ed[9] = 8'h02;  edv[9] = 1'b1;
        ed[10] = 8'h03; edv[10] = 1'b1;
        ed[11] = 8'h04; edv[11] = 1'b1;
        push0(8'h01, 1'b0);
        push0(8'h02, 1'b0);
        push0(8'h03, 1'b0);
        push0(8'h04, 1'b1);
        saw_r1 = 1'b0;
        saw_un = 1'b0;
        for (int k = 0; k < 24; k++) begin
            cycle();
            if (o_ready[1]) saw_r1 = 1'b1;
            if (o_underrun) saw_un = 1'b1;
            checks++; if (o_dv !== edv[k]) $display("FAIL single_dv[%0d] got %b want %b", k, o_dv, edv[k]); else passed++;
            checks++; if (o_data !== ed[k]) $display("FAIL single_data[%0d] got %h want %h", k, o_data, ed[k]); else passed++;
            if (k == 0) begin
                checks++; if (o_grant !== 2'b01) $display("FAIL single_grant_start got %b want 01", o_grant); else passed++;
            end
            if (k == 11) begin
                checks++; if (o_grant !== 2'b00) $display("FAIL single_grant_end got %b want 00", o_grant); else passed++;
            end
        end
        checks++; if (saw_r1 !== 1'b0) $display("FAIL single_ready1 got %b want 0", saw_r1); else passed++;
        checks++; if (saw_un !== 1'b0) $display("FAIL single_underrun got %b want 0", saw_un); else passed++;
        checks++; if (o_frame_cnt !== 16'd1) $display("FAIL single_frame_cnt got %0d want 1", o_frame_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        logic       dvl[100];
        logic [7:0] dl[100];
        logic [1:0] gl[100];
        logic [1:0] eg[4];
        logic [7:0] ef[4];
        logic [7:0] el[4];
        int         rise[$];
        int         hi, idx;
        eg = '{2'b01, 2'b10, 2'b01, 2'b10};
        ef = '{8'h10, 8'h20, 8'h13, 8'h23};
        el = '{8'h12, 8'h22, 8'h15, 8'h25};
        do_reset();
        push0(8'h10, 1'b0); push0(8'h11, 1'b0); push0(8'h12, 1'b1);
        push0(8'h13, 1'b0); push0(8'h14, 1'b0); push0(8'h15, 1'b1);
        push1(8'h20, 1'b0); push1(8'h21, 1'b0); push1(8'h22, 1'b1);
        push1(8'h23, 1'b0); push1(8'h24, 1'b0); push1(8'h25, 1'b1);
        for (int k = 0; k < 100; k++) begin
            cycle();
            dvl[k] = o_dv;
            dl[k]  = o_data;
            gl[k]  = o_grant;
        end
        if (dvl[0]) rise.push_back(0);
        for (int k = 1; k < 100; k++)
            if (dvl[k] && !dvl[k-1]) rise.push_back(k);
        checks++; if (rise.size() !== 4) $display("FAIL b2b_frames got %0d want 4", rise.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (i < rise.size()) begin
                checks++; if (rise[i] !== 23 * i) $display("FAIL b2b_rise[%0d] got %0d want %0d", i, rise[i], 23 * i); else passed++;
                checks++; if (gl[rise[i]] !== eg[i]) $display("FAIL b2b_grant[%0d] got %b want %b", i, gl[rise[i]], eg[i]); else passed++;
                idx = rise[i] + 8;
                if (idx < 100) begin
                    checks++; if (dl[idx] !== ef[i]) $display("FAIL b2b_first[%0d] got %h want %h", i, dl[idx], ef[i]); else passed++;
                end
                idx = rise[i] + 10;
                if (idx < 100) begin
                    checks++; if (dl[idx] !== el[i]) $display("FAIL b2b_last[%0d] got %h want %h", i, dl[idx], el[i]); else passed++;
                end
                hi = 0;
                for (int k = rise[i]; k < 100; k++) begin
                    if (!dvl[k]) break;
                    hi++;
                end
                checks++; if (hi !== 11) $display("FAIL b2b_len[%0d] got %0d want 11", i, hi); else passed++;
                if (i > 0) begin
                    checks++; if (rise[i] - rise[i-1] - 11 !== 12) $display("FAIL b2b_gap[%0d] got %0d want 12", i, rise[i] - rise[i-1] - 11); else passed++;
                end
            end
        end
        checks++; if (o_frame_cnt !== 16'd4) $display("FAIL b2b_frame_cnt got %0d want 4", o_frame_cnt); else passed++;
    endtask

    task automatic test_underrun();
        int   hold, nx, un_cnt, un_at;
        logic saw_r0, bad_low;
        do_reset();
        push1(8'h31, 1'b0); push1(8'h32, 1'b0); push1(8'h33, 1'b0);
        push1(8'h34, 1'b0); push1(8'h35, 1'b1);
        hold = 0;
        un_cnt = 0;
        un_at = -1;
        saw_r0 = 1'b0;
        bad_low = 1'b0;
        for (int k = 0; k < 29; k++) begin
            if (k == 2) begin
                push0(8'h41, 1'b0);
                push0(8'h42, 1'b1);
            end
            nx = 5 - q1.size();
            if (nx == 2 && hold < 3) begin
                en1 = 1'b0;
                hold++;
            end else begin
                en1 = 1'b1;
            end
            cycle();
            if (o_underrun) begin
                un_cnt++;
                un_at = k;
            end
            if (k < 28 && o_ready[0]) saw_r0 = 1'b1;
            if (k >= 10 && k < 28 && (o_dv !== 1'b0 || o_data !== 8'h00)) bad_low = 1'b1;
            if (k == 8) begin
                checks++; if (o_data !== 8'h31) $display("FAIL ur_byte0 got %h want 31", o_data); else passed++;
            end
            if (k == 9) begin
                checks++; if (o_data !== 8'h32) $display("FAIL ur_byte1 got %h want 32", o_data); else passed++;
            end
            if (k == 12) begin
                checks++; if (o_grant !== 2'b10) $display("FAIL ur_drain_grant got %b want 10", o_grant); else passed++;
            end
            if (k == 27) begin
                checks++; if (o_frame_cnt !== 16'd0) $display("FAIL ur_frame_cnt got %0d want 0", o_frame_cnt); else passed++;
                checks++; if (q1.size() !== 0) $display("FAIL ur_drained got %0d left want 0", q1.size()); else passed++;
            end
            if (k == 28) begin
                checks++; if (o_dv !== 1'b1) $display("FAIL ur_next_dv got %b want 1", o_dv); else passed++;
                checks++; if (o_grant !== 2'b01) $display("FAIL ur_next_grant got %b want 01", o_grant); else passed++;
            end
        end
        checks++; if (un_cnt !== 1) $display("FAIL ur_pulses got %0d want 1", un_cnt); else passed++;
        checks++; if (un_at !== 10) $display("FAIL ur_pulse_at got %0d want 10", un_at); else passed++;
        checks++; if (bad_low !== 1'b0) $display("FAIL ur_wire_low got %b want 0", bad_low); else passed++;
        checks++; if (saw_r0 !== 1'b0) $display("FAIL ur_ready0 got %b want 0", saw_r0); else passed++;
        for (int k = 0; k < 30; k++) cycle();
        checks++; if (o_frame_cnt !== 16'd1) $display("FAIL ur_after_cnt got %0d want 1", o_frame_cnt); else passed++;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        push0(8'h60, 1'b0); push0(8'h61, 1'b0); push0(8'h62, 1'b0);
        push0(8'h63, 1'b0); push0(8'h64, 1'b0); push0(8'h65, 1'b1);
        for (int k = 0; k < 10; k++) cycle();
        checks++; if (o_data !== 8'h61) $display("FAIL mid_payload got %h want 61", o_data); else passed++;
        i_reset = 1'b1;
        drive();
        #1;
        checks++; if (o_ready !== 2'b00) $display("FAIL mid_ready got %b want 00", o_ready); else passed++;
        cycle();
        checks++; if (o_dv !== 1'b0) $display("FAIL mid_dv got %b want 0", o_dv); else passed++;
        checks++; if (o_data !== 8'h00) $display("FAIL mid_data got %h want 00", o_data); else passed++;
        checks++; if (o_grant !== 2'b00) $display("FAIL mid_grant got %b want 00", o_grant); else passed++;
        checks++; if (o_underrun !== 1'b0) $display("FAIL mid_underrun got %b want 0", o_underrun); else passed++;
        i_reset = 1'b0;
        q0.delete();
        q1.delete();
        push0(8'h70, 1'b1);
        push1(8'h80, 1'b1);
        cycle();
        checks++; if (o_dv !== 1'b1) $display("FAIL mid_restart_dv got %b want 1", o_dv); else passed++;
        checks++; if (o_data !== 8'h55) $display("FAIL mid_restart_data got %h want 55", o_data); else passed++;
        checks++; if (o_grant !== 2'b01) $display("FAIL mid_restart_grant got %b want 01", o_grant); else passed++;
        for (int k = 0; k < 50; k++) cycle();
        checks++; if (o_frame_cnt !== 16'd2) $display("FAIL mid_frame_cnt got %0d want 2", o_frame_cnt); else passed++;
    endtask

    task automatic test_short_params();
        logic edv;
        do_reset();
        s_data[0] = 8'hA0;
        s_data[1] = 8'hB0;
        s_last    = 2'b11;
        s_valid   = 2'b11;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            edv = ((k % 4) != 3);
            checks++; if (s_dv !== edv) $display("FAIL short_dv[%0d] got %b want %b", k, s_dv, edv); else passed++;
            if (k == 0 || k == 8) begin
                checks++; if (s_grant !== 2'b01) $display("FAIL short_grant[%0d] got %b want 01", k, s_grant); else passed++;
            end
            if (k == 4) begin
                checks++; if (s_grant !== 2'b10) $display("FAIL short_grant[%0d] got %b want 10", k, s_grant); else passed++;
            end
            if (k == 1) begin
                checks++; if (s_odata !== 8'hD5) $display("FAIL short_sfd got %h want d5", s_odata); else passed++;
            end
            if (k == 2 || k == 10) begin
                checks++; if (s_odata !== 8'hA0) $display("FAIL short_byte[%0d] got %h want a0", k, s_odata); else passed++;
            end
            if (k == 6) begin
                checks++; if (s_odata !== 8'hB0) $display("FAIL short_byte[%0d] got %h want b0", k, s_odata); else passed++;
            end
        end
        s_valid = 2'b00;
        s_last  = 2'b00;
    endtask

    task automatic test_frame_wrap();
        do_reset();
        force dut.frame_cnt_q = 16'hFFFF;
        cycle();
        release dut.frame_cnt_q;
        cycle();
        checks++; if (o_frame_cnt !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", o_frame_cnt); else passed++;
        push0(8'h90, 1'b1);
        for (int k = 0; k < 14; k++) cycle();
        checks++; if (o_frame_cnt !== 16'h0000) $display("FAIL wrap_count got %h want 0000", o_frame_cnt); else passed++;
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 2'b00;
        i_data  = '0;
        i_last  = 2'b00;
        s_valid = 2'b00;
        s_data  = '0;
        s_last  = 2'b00;
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underrun();
        test_reset_midframe();
        test_short_params();
        test_frame_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
